// File: rtl/act_writeback_scheduler.sv
// -----------------------------------------------------------------------------
// act_writeback_scheduler
//
// Arbitrates the activation-memory write port between two sources:
//   * external activation loading: one word per accepted load_valid beat,
//     written at an auto-incrementing load pointer;
//   * PE-array tile writeback: NB_TRANSFERS output words, one per PE column,
//     written at drain_base, drain_base + stride, ...
//
// The requantisation (mapping) register sits between the column mux and the
// memory. Writeback therefore trails the column index by one cycle, and one
// FLUSH cycle follows the last DRAIN cycle to write the final word.
//
// Ports
//   clk                      rising-edge clock
//   arst_n_in                asynchronous active-low reset
//   load_valid / load_ready  external word handshake (IDLE only)
//   load_ptr_set, load_base  reload the load pointer (any state, set wins)
//   drain_start              begin tile writeback (accepted in IDLE only)
//   drain_base, drain_stride first address / increment, sampled on start
//   transfer_index           PE column driving the output mux
//   ce_mapping               clock enable of the mapping register stage
//   write_activations_memory memory chip select, active-low (0 = write)
//   mem_addr                 write address
//   outputs_to_memory_flag   data source: 1 = packed outputs, 0 = external
//   output_valid             writeback beat this cycle
//   drain_busy               drain in progress (DRAIN or FLUSH)
//   drain_done               single-cycle pulse in the FLUSH cycle
// -----------------------------------------------------------------------------
module act_writeback_scheduler #(
    parameter int ADDR_WIDTH_ACT = 14,
    parameter int NB_TRANSFERS   = 16
) (
    input  logic                      clk,
    input  logic                      arst_n_in,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic                      load_ptr_set,
    input  logic [ADDR_WIDTH_ACT-1:0] load_base,
    input  logic                      drain_start,
    input  logic [ADDR_WIDTH_ACT-1:0] drain_base,
    input  logic [ADDR_WIDTH_ACT-1:0] drain_stride,
    output logic [3:0]                transfer_index,
    output logic                      ce_mapping,
    output logic                      write_activations_memory,
    output logic [ADDR_WIDTH_ACT-1:0] mem_addr,
    output logic                      outputs_to_memory_flag,
    output logic                      output_valid,
    output logic                      drain_busy,
    output logic                      drain_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] LAST_INDEX = 4'(NB_TRANSFERS - 1);

    state_t                    state_reg,    state_next;
    logic [3:0]                index_reg,    index_next;
    logic [ADDR_WIDTH_ACT-1:0] load_ptr_reg, load_ptr_next;
    logic [ADDR_WIDTH_ACT-1:0] stride_reg,   stride_next;
    // Running writeback address: starts at drain_base and gains one stride
    // per written beat, so no multiplier is needed.
    logic [ADDR_WIDTH_ACT-1:0] wb_addr_reg,  wb_addr_next;
    logic                      load_accept;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_reg    <= IDLE;
            index_reg    <= '0;
            load_ptr_reg <= '0;
            stride_reg   <= '0;
            wb_addr_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            index_reg    <= index_next;
            load_ptr_reg <= load_ptr_next;
            stride_reg   <= stride_next;
            wb_addr_reg  <= wb_addr_next;
        end
    end

    always_comb begin
        state_next               = state_reg;
        index_next               = index_reg;
        stride_next              = stride_reg;
        wb_addr_next             = wb_addr_reg;
        load_accept              = 1'b0;
        load_ready               = 1'b0;
        ce_mapping               = 1'b0;
        transfer_index           = 4'd0;
        write_activations_memory = 1'b1;
        mem_addr                 = load_ptr_reg;
        outputs_to_memory_flag   = 1'b0;
        output_valid             = 1'b0;
        drain_busy               = 1'b0;
        drain_done               = 1'b0;

        case (state_reg)
            IDLE: begin
                // A drain request takes the port ahead of a coincident load.
                load_ready = !drain_start;
                if (drain_start) begin
                    state_next   = DRAIN;
                    index_next   = 4'd0;
                    stride_next  = drain_stride;
                    wb_addr_next = drain_base;
                end else if (load_valid) begin
                    load_accept              = 1'b1;
                    write_activations_memory = 1'b0;
                end
            end

            DRAIN: begin
                drain_busy     = 1'b1;
                ce_mapping     = 1'b1;
                transfer_index = index_reg;
                index_next     = index_reg + 4'd1;
                if (index_reg == LAST_INDEX) begin
                    state_next = FLUSH;
                    index_next = 4'd0;
                end
                // Column 0 is still in the mapping register at index 0.
                if (index_reg != 4'd0) begin
                    write_activations_memory = 1'b0;
                    outputs_to_memory_flag   = 1'b1;
                    output_valid             = 1'b1;
                    mem_addr                 = wb_addr_reg;
                    wb_addr_next             = wb_addr_reg + stride_reg;
                end
            end

            FLUSH: begin
                drain_busy               = 1'b1;
                drain_done               = 1'b1;
                write_activations_memory = 1'b0;
                outputs_to_memory_flag   = 1'b1;
                output_valid             = 1'b1;
                mem_addr                 = wb_addr_reg;
                wb_addr_next             = wb_addr_reg + stride_reg;
                state_next               = IDLE;
            end

            default: begin
                state_next = IDLE;
                index_next = 4'd0;
            end
        endcase

        // Pointer reload wins over the increment; the coincident beat has
        // already been addressed with the old pointer above.
        if (load_ptr_set) begin
            load_ptr_next = load_base;
        end else if (load_accept) begin
            load_ptr_next = load_ptr_reg + 1'b1;
        end else begin
            load_ptr_next = load_ptr_reg;
        end
    end

endmodule

// File: tb/tb_act_writeback_scheduler.sv
// -----------------------------------------------------------------------------
// Bench for act_writeback_scheduler. The stimulus process pushes every write
// it expects onto a queue; the monitor pops one entry per observed memory
// write and compares address and data source. Control outputs are checked
// inline against hand-derived cycle expectations.
// -----------------------------------------------------------------------------
module tb_act_writeback_scheduler;

    localparam int AW = 14;
    localparam int NT = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          flag;
    } wr_t;

    logic          clk;
    logic          arst_n_in;
    logic          load_valid;
    logic          load_ready;
    logic          load_ptr_set;
    logic [AW-1:0] load_base;
    logic          drain_start;
    logic [AW-1:0] drain_base;
    logic [AW-1:0] drain_stride;
    logic [3:0]    transfer_index;
    logic          ce_mapping;
    logic          write_activations_memory;
    logic [AW-1:0] mem_addr;
    logic          outputs_to_memory_flag;
    logic          output_valid;
    logic          drain_busy;
    logic          drain_done;

    wr_t exp_q[$];
    int  checks_total;
    int  checks_passed;

    act_writeback_scheduler #(
        .ADDR_WIDTH_ACT(AW),
        .NB_TRANSFERS  (NT)
    ) dut (
        .clk                     (clk),
        .arst_n_in               (arst_n_in),
        .load_valid              (load_valid),
        .load_ready              (load_ready),
        .load_ptr_set            (load_ptr_set),
        .load_base               (load_base),
        .drain_start             (drain_start),
        .drain_base              (drain_base),
        .drain_stride            (drain_stride),
        .transfer_index          (transfer_index),
        .ce_mapping              (ce_mapping),
        .write_activations_memory(write_activations_memory),
        .mem_addr                (mem_addr),
        .outputs_to_memory_flag  (outputs_to_memory_flag),
        .output_valid            (output_valid),
        .drain_busy              (drain_busy),
        .drain_done              (drain_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (arst_n_in === 1'b1 && write_activations_memory === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_flag", 32'(outputs_to_memory_flag), 32'(e.flag));
                chk("wr_valid", 32'(output_valid), 32'(e.flag));
            end
        end else if (arst_n_in === 1'b1 && (output_valid !== 1'b0 || outputs_to_memory_flag !== 1'b0)) begin
            chk("idle_valid_flag", 32'({output_valid, outputs_to_memory_flag}), 32'd0);
        end
    end

    task automatic push_wr(input logic [AW-1:0] a, input logic f);
        wr_t e;
        e.addr = a;
        e.flag = f;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        load_valid   = 1'b0;
        load_ptr_set = 1'b0;
        drain_start  = 1'b0;
    endtask

    // One accepted load beat at exp_addr; optional pointer reload alongside.
    task automatic load_beat(input logic [AW-1:0] exp_addr, input logic set, input logic [AW-1:0] base);
        @(posedge clk); #1;
        load_valid   = 1'b1;
        load_ptr_set = set;
        load_base    = base;
        push_wr(exp_addr, 1'b0);
        @(negedge clk);
        chk("load_ready_beat", 32'(load_ready), 32'd1);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Full drain; if with_load, load_valid is held high from the start cycle
    // and must be accepted only on the first IDLE cycle, at load_exp.
    task automatic drain_run(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                             input logic with_load, input logic [AW-1:0] load_exp);
        logic [AW-1:0] a;
        @(posedge clk); #1;
        drain_start  = 1'b1;
        drain_base   = base;
        drain_stride = stride;
        load_valid   = with_load;
        a = base;
        for (int i = 0; i < NT; i++) begin
            push_wr(a, 1'b1);
            a = a + stride;
        end
        if (with_load) push_wr(load_exp, 1'b0);
        @(negedge clk);
        chk("start_load_ready", 32'(load_ready), 32'd0);
        for (int c = 1; c <= NT + 1; c++) begin
            @(posedge clk); #1;
            // A second start mid-drain with different operands must be ignored.
            drain_start  = (c == 5);
            drain_base   = 14'h1234;
            drain_stride = 14'h0777;
            @(negedge clk);
            chk("ce_mapping", 32'(ce_mapping), (c <= NT) ? 32'd1 : 32'd0);
            chk("transfer_index", 32'(transfer_index), (c <= NT) ? 32'(c - 1) : 32'd0);
            chk("drain_busy", 32'(drain_busy), 32'd1);
            chk("drain_done", 32'(drain_done), (c == NT + 1) ? 32'd1 : 32'd0);
            chk("drain_load_ready", 32'(load_ready), 32'd0);
        end
        @(posedge clk); #1;
        drain_start = 1'b0;
        @(negedge clk);
        chk("post_busy", 32'(drain_busy), 32'd0);
        chk("post_ready", 32'(load_ready), 32'd1);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        arst_n_in     = 1'b0;
        load_base     = '0;
        drain_base    = '0;
        drain_stride  = '0;
        idle_inputs();
        #2;
        chk("rst_wr_n", 32'(write_activations_memory), 32'd1);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_busy", 32'(drain_busy), 32'd0);
        chk("rst_done", 32'(drain_done), 32'd0);
        chk("rst_ce", 32'(ce_mapping), 32'd0);
        chk("rst_index", 32'(transfer_index), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_valid", 32'(output_valid), 32'd0);
        chk("rst_flag", 32'(outputs_to_memory_flag), 32'd0);
        @(posedge clk); #1;
        arst_n_in = 1'b1;

        // Pointer set to 0x0100, then three beats.
        @(posedge clk); #1;
        load_ptr_set = 1'b1;
        load_base    = 14'h0100;
        @(posedge clk); #1;
        idle_inputs();
        load_beat(14'h0100, 1'b0, '0);
        load_beat(14'h0101, 1'b0, '0);
        load_beat(14'h0102, 1'b0, '0);

        // Drain with coincident load; the load lands at 0x0103 afterwards.
        drain_run(14'h2000, 14'd4, 1'b1, 14'h0103);

        // Set coincident with a beat: beat at old pointer 0x0104, then wrap.
        load_beat(14'h0104, 1'b1, 14'h3FFF);
        load_beat(14'h3FFF, 1'b0, '0);
        load_beat(14'h0000, 1'b0, '0);
        drain_run(14'h3FF8, 14'd1, 1'b0, '0);

        // Reset at index 7: only the first six beats are ever written.
        @(posedge clk); #1;
        drain_start  = 1'b1;
        drain_base   = 14'h1000;
        drain_stride = 14'd2;
        for (int i = 0; i < 6; i++) push_wr(14'h1000 + 14'(2 * i), 1'b1);
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            drain_start = 1'b0;
        end
        @(posedge clk); #1;
        chk("pre_rst_index", 32'(transfer_index), 32'd7);
        arst_n_in = 1'b0;
        #1;
        chk("abort_wr_n", 32'(write_activations_memory), 32'd1);
        chk("abort_busy", 32'(drain_busy), 32'd0);
        chk("abort_done", 32'(drain_done), 32'd0);
        chk("abort_ce", 32'(ce_mapping), 32'd0);
        @(posedge clk); #1;
        arst_n_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("no_done_after_abort", 32'(drain_done), 32'd0);
        end
        // Pointer was cleared by reset; a fresh drain restarts at index 0.
        load_beat(14'h0000, 1'b0, '0);
        drain_run(14'h0040, 14'd3, 1'b0, '0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
